// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle MIPS datapath.
// Memory-stage FSM states, instruction field positions, default widths.
package mcpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } memState_t;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_access_unit_if.sv
// External memory bus: single-outstanding req/ack.
// master = memory-access stage, slave = memory.
interface mem_access_unit_if
  import mcpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Bus wait counter; expired is high in the TIMEOUT-th enabled cycle.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: runs bus transactions, loads IR/MDR.
// Optional bus timeout with sticky err when MEM_TIMEOUT_EN is defined.
module mem_access_unit
  import mcpu_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iord,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ir_write,
  output logic              busy,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic              err,
  mem_access_unit_if.master bus
);

  memState_t state;
  memState_t nextState;

  logic              start;
  logic              ackHit;
  logic              timedOut;
  logic              irWriteQ;
  logic              weQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;

  assign start  = (state == IDLE) && (mem_read || mem_write);
  assign ackHit = (state == BUS) && bus.bus_ack;

`ifdef MEM_TIMEOUT_EN
  logic expired;
  logic errQ;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != BUS),
    .enable  (state == BUS),
    .expired (expired)
  );

  // An ack in the final wait cycle still completes normally
  assign timedOut = expired && !bus.bus_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errQ <= 1'b0;
    end else if (timedOut) begin
      errQ <= 1'b1;
    end
  end

  assign err = errQ;
`else
  assign timedOut = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (start) nextState = BUS;
      BUS:  if (bus.bus_ack || timedOut) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrQ    <= '0;
      wdataQ   <= '0;
      weQ      <= 1'b0;
      irWriteQ <= 1'b0;
      ir       <= '0;
      mdr      <= '0;
    end else begin
      if (start) begin
        addrQ    <= iord ? alu_out : pc;
        wdataQ   <= wdata;
        weQ      <= mem_write;
        irWriteQ <= ir_write && !mem_write;
      end
      if (ackHit && !weQ) begin
        mdr <= bus.bus_rdata;
        if (irWriteQ) ir <= bus.bus_rdata;
      end
    end
  end

  assign busy          = (state == BUS);
  assign bus.bus_req   = (state == BUS);
  assign bus.bus_we    = weQ;
  assign bus.bus_addr  = addrQ;
  assign bus.bus_wdata = wdataQ;

  assign op    = ir[OP_HI:OP_LO];
  assign funct = ir[FUNCT_HI:FUNCT_LO];

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: fetch, load, store,
// busy-time strobes, stray ack, async reset, timeout.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iord = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] alu_out = '0;
  logic [31:0] wdata = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        ir_write = 1'b0;
  logic        busy;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        err;

  int nCmp = 0;
  int nErr = 0;

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) busIf ();

  mem_access_unit #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iord      (iord),
    .pc        (pc),
    .alu_out   (alu_out),
    .wdata     (wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .ir_write  (ir_write),
    .busy      (busy),
    .ir        (ir),
    .mdr       (mdr),
    .op        (op),
    .funct     (funct),
    .err       (err),
    .bus       (busIf.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    busIf.bus_ack   = 1'b0;
    busIf.bus_rdata = '0;

    // reset state
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(busIf.bus_req), 32'd0);
    check("rst_we", 32'(busIf.bus_we), 32'd0);
    check("rst_addr", busIf.bus_addr, 32'h0);
    check("rst_wdata", busIf.bus_wdata, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_mdr", mdr, 32'h0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    step();

    // fetch, ack after 3 wait cycles
    pc = 32'h40; iord = 1'b0; mem_read = 1'b1; ir_write = 1'b1;
    step();
    mem_read = 1'b0; ir_write = 1'b0;
    check("f_busy1", 32'(busy), 32'd1);
    check("f_req", 32'(busIf.bus_req), 32'd1);
    check("f_addr", busIf.bus_addr, 32'h40);
    check("f_we", 32'(busIf.bus_we), 32'd0);
    step();
    check("f_busy2", 32'(busy), 32'd1);
    step();
    check("f_busy3", 32'(busy), 32'd1);
    step();
    check("f_busy4", 32'(busy), 32'd1);
    busIf.bus_ack = 1'b1; busIf.bus_rdata = 32'h0123_4820;
    step();
    busIf.bus_ack = 1'b0; busIf.bus_rdata = 32'hFFFF_FFFF;
    check("f_done", 32'(busy), 32'd0);
    check("f_ir", ir, 32'h0123_4820);
    check("f_mdr", mdr, 32'h0123_4820);
    check("f_op", 32'(op), 32'h00);
    check("f_funct", 32'(funct), 32'h20);

    // back-to-back load, immediate ack
    iord = 1'b1; alu_out = 32'h100; mem_read = 1'b1;
    step();
    mem_read = 1'b0;
    check("l_busy", 32'(busy), 32'd1);
    check("l_addr", busIf.bus_addr, 32'h100);
    busIf.bus_ack = 1'b1; busIf.bus_rdata = 32'hDEAD_BEEF;
    step();
    busIf.bus_ack = 1'b0;
    check("l_done", 32'(busy), 32'd0);
    check("l_mdr", mdr, 32'hDEAD_BEEF);
    check("l_ir", ir, 32'h0123_4820);

    // store with ir_write also high: write wins
    alu_out = 32'h200; wdata = 32'hCAFE_F00D;
    mem_write = 1'b1; ir_write = 1'b1;
    step();
    mem_write = 1'b0; ir_write = 1'b0;
    wdata = 32'h0; alu_out = 32'h0;
    check("s_we", 32'(busIf.bus_we), 32'd1);
    check("s_addr", busIf.bus_addr, 32'h200);
    check("s_wdata1", busIf.bus_wdata, 32'hCAFE_F00D);
    step();
    check("s_wdata2", busIf.bus_wdata, 32'hCAFE_F00D);
    check("s_busy", 32'(busy), 32'd1);
    busIf.bus_ack = 1'b1; busIf.bus_rdata = 32'h5555_5555;
    step();
    busIf.bus_ack = 1'b0;
    check("s_done", 32'(busy), 32'd0);
    check("s_mdr", mdr, 32'hDEAD_BEEF);
    check("s_ir", ir, 32'h0123_4820);

    // stray ack in IDLE
    busIf.bus_ack = 1'b1; busIf.bus_rdata = 32'h1111_1111;
    step();
    busIf.bus_ack = 1'b0;
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_mdr", mdr, 32'hDEAD_BEEF);

    // strobes pulsed while busy are ignored
    iord = 1'b1; alu_out = 32'h300; mem_read = 1'b1;
    step();
    mem_read = 1'b0;
    alu_out = 32'h400; wdata = 32'h9999_9999; mem_write = 1'b1;
    step();
    mem_write = 1'b0;
    check("b_addr", busIf.bus_addr, 32'h300);
    check("b_we", 32'(busIf.bus_we), 32'd0);
    busIf.bus_ack = 1'b1; busIf.bus_rdata = 32'h0000_0077;
    step();
    busIf.bus_ack = 1'b0;
    check("b_mdr", mdr, 32'h0000_0077);
    check("b_idle1", 32'(busy), 32'd0);
    step();
    check("b_idle2", 32'(busIf.bus_req), 32'd0);

    // async reset mid-transaction
    iord = 1'b0; pc = 32'h500; mem_read = 1'b1; ir_write = 1'b1;
    step();
    mem_read = 1'b0; ir_write = 1'b0;
    check("r_req_pre", 32'(busIf.bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("r_req_async", 32'(busIf.bus_req), 32'd0);
    check("r_ir", ir, 32'h0);
    check("r_mdr", mdr, 32'h0);
    step();
    rst_n = 1'b1;
    busIf.bus_ack = 1'b1; busIf.bus_rdata = 32'hBAD0_BAD0;
    step();
    busIf.bus_ack = 1'b0;
    check("r_late_busy", 32'(busy), 32'd0);
    check("r_late_mdr", mdr, 32'h0);

`ifdef MEM_TIMEOUT_EN
    // no ack: bus_req for exactly 15 cycles, then sticky err
    iord = 1'b1; alu_out = 32'h600; mem_read = 1'b1;
    step();
    mem_read = 1'b0;
    begin
      int reqCycles = 0;
      for (int i = 0; i < 40 && busIf.bus_req; i++) begin
        reqCycles++;
        step();
      end
      check("t_cycles", 32'(reqCycles), 32'd15);
    end
    check("t_err", 32'(err), 32'd1);
    check("t_mdr", mdr, 32'h0);
    pc = 32'h80; iord = 1'b0; mem_read = 1'b1; ir_write = 1'b1;
    step();
    mem_read = 1'b0; ir_write = 1'b0;
    busIf.bus_ack = 1'b1; busIf.bus_rdata = 32'h8C01_0004;
    step();
    busIf.bus_ack = 1'b0;
    check("t_ir", ir, 32'h8C01_0004);
    check("t_op", 32'(op), 32'h23);
    check("t_err_sticky", 32'(err), 32'd1);
`else
    // no timeout: BUS waits indefinitely, err stays 0
    iord = 1'b1; alu_out = 32'h600; mem_read = 1'b1;
    step();
    mem_read = 1'b0;
    repeat (20) step();
    check("w_busy", 32'(busy), 32'd1);
    check("w_err", 32'(err), 32'd0);
    busIf.bus_ack = 1'b1; busIf.bus_rdata = 32'h8C01_0004;
    step();
    busIf.bus_ack = 1'b0;
    check("w_mdr", mdr, 32'h8C01_0004);
    check("w_done", 32'(busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage of the multi-cycle MIPS datapath, directly downstream of the main controller FSM. Consumes the controller's IorD/MemRead/MemWrite/IRWrite strobes, runs a req/ack transaction on the external memory bus, and latches read data into the Instruction Register (IR) and Memory Data Register (MDR). Raises `busy` so the controller can hold its current state while memory latency is variable.

## Interface
Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width
- TIMEOUT, 15, maximum wait cycles for `bus_ack` (used only with MEM_TIMEOUT_EN)

Ports (single clock `clk`; reset `rst_n` is asynchronous, active-low):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- iord  in  1  address select: 0 = `pc`, 1 = `alu_out`
- pc  in  ADDR_W  program counter
- alu_out  in  ADDR_W  ALUOut register (data address)
- wdata  in  DATA_W  store data (B register)
- mem_read  in  1  read command strobe
- mem_write  in  1  write command strobe
- ir_write  in  1  route read data into IR as well as MDR
- busy  out  1  transaction in flight
- ir  out  DATA_W  instruction register
- mdr  out  DATA_W  memory data register
- op  out  6  ir[31:26]
- funct  out  6  ir[5:0]
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_ack  in  1  transaction complete
- bus_rdata  in  DATA_W  read data, valid with `bus_ack`
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, BUS.
- IDLE: if `mem_read | mem_write` at a rising edge, capture address (`iord` mux), `wdata`, `bus_we = mem_write`, and a private copy of `ir_write`; go to BUS. Both strobes high: write wins, `ir_write` ignored.
- BUS: `bus_req = 1`; `bus_addr`, `bus_we`, `bus_wdata` held stable from capture until the ack cycle. On `bus_ack`: if read, `mdr <= bus_rdata`; if the captured ir_write copy is set, also `ir <= bus_rdata`; go to IDLE.
- Writes never modify `ir`/`mdr`.
- `busy = (state == BUS)`, registered.
- Strobes seen while in BUS are ignored; the controller must hold state while `busy`.
- `bus_ack` in IDLE is ignored.
- `op`/`funct` are pure slices of `ir`.
- Reset values: state IDLE; `ir`, `mdr`, `bus_addr`, `bus_wdata` = 0; `bus_req`, `bus_we`, `busy`, `err` = 0.
- Reset mid-transaction: `bus_req` drops asynchronously and the transaction is abandoned; a late ack after reset release is ignored.

## Timing
- Command sampled at edge N; `bus_req`/`busy` high from cycle N+1.
- Ack in cycle N+1+k (k ≥ 0): `ir`/`mdr` updated at that edge; `busy` low and new data visible in cycle N+2+k.
- Minimum latency 2 cycles command-to-data; back-to-back commands accepted in the first IDLE cycle.
- Bus side is single-outstanding; the memory must hold `bus_rdata` valid during the ack cycle only.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A wait counter runs in BUS and clears on entry.
  - If TIMEOUT cycles pass without `bus_ack`: drop `bus_req`, return to IDLE, leave `ir`/`mdr` unchanged, and set `err`.
  - `err` is sticky until reset.
- `MEM_TIMEOUT_EN` undefined: no counter; BUS waits indefinitely; `err` tied 0.

## Structure
- Shared package `mcpu_pkg`: state enum (IDLE, BUS), OP/funct field bit positions, default ADDR_W/DATA_W.
- Sub-module `mem_timeout_ctr` (clear, enable, expired; width $clog2(TIMEOUT+1)), instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- Reset, then fetch: pc=0x0000_0040, iord=0, mem_read=ir_write=1 for one cycle, ack after 3 wait cycles with rdata=0x0123_4820 -> bus_addr=0x40, busy high 4 cycles, ir=mdr=0x0123_4820, op=0x00, funct=0x20.
- Load: iord=1, alu_out=0x100, mem_read=1, ir_write=0, immediate ack with rdata=0xDEAD_BEEF -> mdr=0xDEAD_BEEF, ir unchanged, busy high exactly 1 cycle.
- Store: mem_write=1, wdata=0xCAFE_F00D, alu_out=0x200 -> bus_we=1, bus_wdata stable until ack, ir/mdr unchanged.
- Strobes pulsed while busy, plus stray ack in IDLE -> no second transaction, registers unchanged.
- rst_n low in BUS -> bus_req low without a clock edge, ir/mdr=0; ack after release ignored.
- With MEM_TIMEOUT_EN and TIMEOUT=15, no ack -> bus_req drops after 15 BUS cycles, err=1 and stays 1; next fetch still completes.
